// File: rtl/ucode_seq.sv
// rtl/ucode_seq.sv - writable microcode control store with integrated microsequencer
//
// Purpose: holds DEPTH control words loaded through a write port and fetches one
// word per enabled cycle. The fetch address comes from a sequencing operation
// (next, jump, conditional branch, call, return, hold) backed by a bounded
// return stack.
//
// Ports:
//   clk2      in   clock, all state changes on its rising edge
//   reset     in   asynchronous active-low reset
//   en        in   advance enable; 0 freezes everything except store writes
//   restart   in   synchronous restart, honoured only when en=1
//   seq_op    in   sequencing operation for the word currently on cword
//   cond      in   branch condition for BRC
//   jmp_addr  in   target for JMP/BRC/CALL
//   ld_en     in   store write strobe
//   ld_addr   in   store write address
//   ld_data   in   store write data
//   cword     out  current control word (registered)
//   cw_addr   out  address of the current control word
//   cw_valid  out  cword holds a fetched word
//   seq_err   out  sticky stack overflow/underflow flag

module ucode_seq #(
    parameter int CW_WIDTH    = 21,
    parameter int DEPTH       = 8,
    parameter int START_ADDR  = 1,
    parameter int STACK_DEPTH = 2,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                clk2,
    input  logic                reset,
    input  logic                en,
    input  logic                restart,
    input  logic [2:0]          seq_op,
    input  logic                cond,
    input  logic [AW-1:0]       jmp_addr,
    input  logic                ld_en,
    input  logic [AW-1:0]       ld_addr,
    input  logic [CW_WIDTH-1:0] ld_data,
    output logic [CW_WIDTH-1:0] cword,
    output logic [AW-1:0]       cw_addr,
    output logic                cw_valid,
    output logic                seq_err
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);

    localparam logic [AW-1:0]  START   = AW'(START_ADDR);
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);

    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BRC  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HOLD = 3'b101;

    logic [CW_WIDTH-1:0] r_mem   [DEPTH];
    logic [AW-1:0]       r_stack [STACK_DEPTH];
    logic [SPW-1:0]      r_sp;
    logic [CW_WIDTH-1:0] r_cword;
    logic [AW-1:0]       r_cw_addr;
    logic                r_cw_valid;
    logic                r_seq_err;

    logic [AW-1:0]       w_next;
    logic [AW-1:0]       w_top;
    logic [AW-1:0]       w_fetch;
    logic                w_push;
    logic                w_pop;
    logic                w_err_set;

    // DEPTH is a power of two, so the natural AW-bit overflow gives the wrap.
    assign w_next = r_cw_addr + AW'(1);

    // Top-of-stack select by compare rather than r_sp-1 indexing, so the
    // pointer width never has to match the array index width.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_sp == SPW'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    always_comb begin
        w_fetch   = START;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        if (!restart && r_cw_valid) begin
            case (seq_op)
                OP_JMP:  w_fetch = jmp_addr;
                OP_BRC:  w_fetch = cond ? jmp_addr : w_next;
                OP_CALL: begin
                    w_fetch = jmp_addr;
                    if (r_sp == SP_FULL) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
                OP_RET: begin
                    if (r_sp == '0) begin
                        w_err_set = 1'b1;
                        w_fetch   = START;
                    end else begin
                        w_pop   = 1'b1;
                        w_fetch = w_top;
                    end
                end
                OP_HOLD: w_fetch = r_cw_addr;
                default: w_fetch = w_next;
            endcase
        end
    end

    // Store is never reset; writes are simply suppressed while reset is low.
    always_ff @(posedge clk2) begin
        if (reset && ld_en) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    // Stack entries carry no reset: validity is tracked entirely by r_sp.
    always_ff @(posedge clk2) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (en && w_push && r_sp == SPW'(i)) begin
                r_stack[i] <= w_next;
            end
        end
    end

    // cword samples r_mem before the same-edge store write lands, which gives
    // read-before-write when ld_addr matches the fetch address.
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            r_cword    <= '0;
            r_cw_addr  <= START;
            r_cw_valid <= 1'b0;
            r_seq_err  <= 1'b0;
            r_sp       <= '0;
        end else if (en) begin
            r_cword    <= r_mem[w_fetch];
            r_cw_addr  <= w_fetch;
            r_cw_valid <= 1'b1;
            if (restart) begin
                r_sp      <= '0;
                r_seq_err <= 1'b0;
            end else begin
                if (w_push) begin
                    r_sp <= r_sp + SP_ONE;
                end else if (w_pop) begin
                    r_sp <= r_sp - SP_ONE;
                end
                if (w_err_set) begin
                    r_seq_err <= 1'b1;
                end
            end
        end
    end

    assign cword    = r_cword;
    assign cw_addr  = r_cw_addr;
    assign cw_valid = r_cw_valid;
    assign seq_err  = r_seq_err;

endmodule

// File: doc/ucode_seq.md
# ucode_seq

Parametrised microcode control store with an integrated microsequencer. It holds a writable store of DEPTH control words and a microprogram counter. Each enabled cycle it fetches one control word, choosing the address through an explicit sequencing operation (next, jump, conditional branch, call, return, hold) backed by a bounded return stack. It sits between the instruction decoder/condition logic and the datapath, and replaces the fixed 8×21 preset control-word register with a loadable store of any width and depth that can sequence itself.

## Interface
Parameters:
- CW_WIDTH, 21, control word width in bits (≥1)
- DEPTH, 8, number of control words; power of two, ≥2; AW = $clog2(DEPTH)
- START_ADDR, 1, first fetch address after reset or restart (< DEPTH)
- STACK_DEPTH, 2, return-stack entries (≥1)

Ports:
- clk2  input  1  clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset
- en  input  1  advance enable; 0 freezes all state except store writes
- restart  input  1  synchronous restart, sampled only when en=1
- seq_op  input  3  sequencing operation for the current word
- cond  input  1  branch condition, used by BRC
- jmp_addr  input  AW  target for JMP/BRC/CALL
- ld_en  input  1  store write strobe
- ld_addr  input  AW  store write address
- ld_data  input  CW_WIDTH  store write data
- cword  output  CW_WIDTH  current control word (registered)
- cw_addr  output  AW  address of the current cword
- cw_valid  output  1  cword holds a fetched word
- seq_err  output  1  sticky stack overflow/underflow flag

## Operation
- Store: DEPTH×CW_WIDTH array. It is not reset and is initialised only through the load port. A write occurs whenever ld_en=1, independent of en and reset state, except while reset is asserted.
- Fetch: on a cycle with en=1, compute fetch address F, then cword<=mem[F], cw_addr<=F, cw_valid<=1.
- Computing F, in priority order:
  - restart=1 or cw_valid=0: F=START_ADDR. Stack is cleared and seq_err cleared when restart=1.
  - Otherwise, by seq_op. Here N = (cw_addr+1) mod DEPTH, so the address wraps from DEPTH-1 to 0.
  - 000 NEXT: F=N
  - 001 JMP: F=jmp_addr
  - 010 BRC: F = cond ? jmp_addr : N
  - 011 CALL: push N, F=jmp_addr. If the stack is full, there is no push, seq_err<=1, and F=jmp_addr.
  - 100 RET: pop, F=top. If the stack is empty, seq_err<=1 and F=START_ADDR.
  - 101 HOLD: F=cw_addr. The word is re-read, so a load to that address becomes visible.
  - 110, 111: treated as NEXT.
- seq_op, cond and jmp_addr describe the word currently on cword. The external decoder derives them from cword combinationally.
- Read-before-write: if ld_en=1 and ld_addr==F in the same cycle, cword receives the old contents. The new data is visible on any later fetch of that address.
- Return stack: LIFO with pointer sp in range 0..STACK_DEPTH. Full means sp==STACK_DEPTH; empty means sp==0.

## Timing
- Reset (reset=0, asynchronous): cword=0, cw_addr=START_ADDR, cw_valid=0, seq_err=0, sp=0. Store writes are blocked while reset is asserted.
- The first rising clk2 edge with reset=1 and en=1 fetches START_ADDR. cw_valid rises on that edge.
- Fetch latency: 1 cycle. The word selected by F appears on cword after the edge on which en=1.
- With en=0, cword, cw_addr, cw_valid, sp and seq_err hold exactly, and restart is ignored.
- seq_err is sticky. Only reset or a restart with en=1 clears it.
- Reset asserted mid-program: all outputs go to their reset values immediately. Store contents are preserved.

## Test plan
- Load and sequence (DEPTH=8, CW_WIDTH=21): load mem[k]=k*3 for k=0..7, release reset, en=1, seq_op=NEXT. Required: cword sequence 3,6,9,12,15,18,21,0,3 and cw_addr sequence 1..7,0,1 (wrap at DEPTH-1).
- Branch: at cw_addr=2, seq_op=BRC, jmp_addr=6. With cond=1 the next cw_addr is 6; repeated with cond=0 it is 3. Then seq_op=JMP to 0 gives cw_addr=0 next.
- Call/return nesting (STACK_DEPTH=2):
  - CALL 5 from address 1, then CALL 7 from 5, then RET, then RET. Required cw_addr: 5,7,6,2, with seq_err=0.
  - A third nested CALL while full sets seq_err=1, still jumps, and does not push.
  - RET on an empty stack sets seq_err=1 and sets cw_addr=START_ADDR.
- Stall, hold and restart:
  - en=0 for 3 cycles mid-program: outputs are frozen.
  - HOLD on address 4 while loading mem[4]=0x1FFFFF: the same cycle still shows the old word; the next cycle shows 0x1FFFFF.
  - restart=1 with en=1: cw_addr=START_ADDR, sp=0, seq_err=0.
- Async reset mid-run: drop reset between clock edges. cword=0, cw_valid=0 and cw_addr=START_ADDR immediately, without a clock edge. The store is unchanged, checked by refetching after release.
- Parametrised build, CW_WIDTH=32, DEPTH=16, START_ADDR=0, STACK_DEPTH=4: rerun the NEXT and call/return scenarios. Wrap occurs 15→0, and four nested CALLs complete without error.
